// File: rtl/seq_divider.sv
// Sequential unsigned divider by repeated subtraction; dividend and divisor share data_in on consecutive cycles.
// Optional abort input enabled by defining SEQ_DIV_ABORT_EN.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
`ifdef SEQ_DIV_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LDB   = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_SUB   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             busy_w;

    assign busy_w = (state_q == S_LDB) || (state_q == S_CHECK) || (state_q == S_SUB);

    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        done_d    = done_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rem_d   = data_in;
                    quot_d  = '0;
                    done_d  = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = S_LDB;
                end
            end
            S_LDB: begin
                divisor_d = data_in;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                // Zero divisor: report saturated quotient and leave the dividend in remainder.
                if (divisor_q == '0) begin
                    dbz_d   = 1'b1;
                    quot_d  = '1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                if (rem_q >= divisor_q) begin
                    rem_d  = rem_q - divisor_q;
                    quot_d = quot_q + ONE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SEQ_DIV_ABORT_EN
        // Abort overrides whatever transition the busy state would have taken.
        if (abort && busy_w) begin
            state_d = S_IDLE;
            quot_d  = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
            done_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_w;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a plain-arithmetic reference (/, %, latency formula).
module tb_seq_divider;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;
`ifdef SEQ_DIV_ABORT_EN
    logic         abort = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
`ifdef SEQ_DIV_ABORT_EN
        .abort       (abort),
`endif
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_q"},    quotient, 0);
        check_val({tag, "_r"},    remainder, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_dbz"},  div_by_zero, 0);
    endtask

    // Drives the two-cycle operand load; returns #1 after edge 0.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start   = 1'b1;
        data_in = a;
        @(posedge clk);
        #1;
        check_val("done_clr", done, 0);
        check_val("busy_ldb", busy, 1);
        start   = 1'b0;
        data_in = b;
    endtask

    // Counts edges after edge 0 until done; optionally pulses start at edge poke_e.
    task automatic wait_done(input int max_e, input int poke_e, input logic [W-1:0] pv, output int lat);
        lat = -1;
        for (int e = 1; e <= max_e; e++) begin
            if (e == poke_e) begin
                start   = 1'b1;
                data_in = pv;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = e;
                break;
            end
            check_val("busy_run", busy, 1);
        end
        if (lat < 0) check_val("timeout_done", done, 1);
    endtask

    task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int poke_e, input logic [W-1:0] pv);
        int          lat;
        int          exp_lat;
        logic [W-1:0] exp_q, exp_r;
        logic        exp_z;
        if (b == 0) begin
            exp_q = {W{1'b1}}; exp_r = a; exp_z = 1'b1; exp_lat = 2;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_z = 1'b0; exp_lat = int'(a / b) + 3;
        end
        start_op(a, b);
        wait_done(exp_lat + 5, poke_e, pv, lat);
        check_val("latency",   lat, exp_lat);
        check_val("quotient",  quotient, exp_q);
        check_val("remainder", remainder, exp_r);
        check_val("dbz",       div_by_zero, exp_z);
        check_val("busy_done", busy, 0);
    endtask

    initial begin
        int a, b, qt;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_check(16'd100, 16'd7, 0, '0);
        run_check(16'd5,   16'd9, 0, '0);
        run_check(16'd42,  16'd0, 0, '0);

        // Reset in the middle of a long operation
        start_op(16'hFFFF, 16'd1);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("no_done_after_rst", done, 0);
        run_check(16'd12, 16'd4, 0, '0);

        // Start pulse while busy must be ignored, then restart from DONE
        run_check(16'd20, 16'd3, 4, 16'd99);
        run_check(16'd9,  16'd9, 0, '0);

`ifdef SEQ_DIV_ABORT_EN
        start_op(16'd200, 16'd1);
        for (int e = 1; e <= 10; e++) begin
            if (e == 10) abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
        check_idle_zero("abort");
        repeat (5) @(posedge clk);
        #1;
        check_val("abort_no_done", done, 0);
        run_check(16'd7, 16'd2, 0, '0);
`endif

        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 65535);
            b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 65535);
            if (b != 0 && a / b > 250) begin
                qt = $urandom_range(0, 250);
                a  = b * qt + $urandom_range(0, b - 1);
            end
            run_check(a[W-1:0], b[W-1:0], 0, '0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
